// File: rtl/gen_multich_buffer_with_spmem.sv
// Multi-channel sliding-window history buffer sharing one single-port memory.
// Optional macro GEN_BUF_IDX_CHECK_EN: out-of-range reads return zero and flag rd_err.
module gen_multich_buffer_with_spmem #(
  parameter int DATA_W  = 8,
  parameter int DEPTH   = 100,
  parameter int NUM_CH  = 4,
  parameter int SIM_DLY = 1,
  localparam int DEPTH_W = $clog2(DEPTH + 1),
  localparam int IDX_W   = $clog2(DEPTH),
  localparam int CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic                      sw_rst,
  input  logic [DEPTH_W-1:0]        cnfg_depth,
  input  logic                      clr_req,
  input  logic [CH_W-1:0]           clr_ch,
  input  logic                      add_req,
  input  logic [CH_W-1:0]           add_ch,
  input  logic [DATA_W-1:0]         i_data,
  output logic                      add_rdy,
  input  logic                      rd_req,
  input  logic [CH_W-1:0]           rd_ch,
  input  logic [IDX_W-1:0]          rd_idx,
  output logic                      o_valid,
  output logic [CH_W-1:0]           o_ch,
  output logic [DATA_W-1:0]         o_data,
  output logic [NUM_CH-1:0]         full,
  output logic [NUM_CH-1:0]         empty,
  output logic [NUM_CH*DEPTH_W-1:0] fullness,
  output logic                      rd_err
);

  localparam int MEM_WORDS = NUM_CH * DEPTH;
  localparam int ADDR_W    = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;

  typedef enum logic [1:0] {IDLE = 2'd0, RD = 2'd1, ADD = 2'd2, CLR = 2'd3} fsmState_e;

  fsmState_e fsm_cs, fsm_ns;

  logic [IDX_W-1:0]   head_q [NUM_CH];
  logic [IDX_W-1:0]   head_d [NUM_CH];
  logic [IDX_W-1:0]   tail_q [NUM_CH];
  logic [IDX_W-1:0]   tail_d [NUM_CH];
  logic [DEPTH_W-1:0] cnt_q  [NUM_CH];
  logic [DEPTH_W-1:0] cnt_d  [NUM_CH];

  logic [DEPTH_W-1:0] cntDepth;
  logic               clrGo, rdGo, addGo;
  logic [IDX_W:0]     rdSum, rdLocal;
  logic [ADDR_W-1:0]  memAddr;
  logic [DATA_W-1:0]  mem [MEM_WORDS];
  logic [DATA_W-1:0]  rdData_q;
  logic [CH_W-1:0]    oCh_q;
  logic               unusedSimDly;

  assign unusedSimDly = ^SIM_DLY;

  function automatic logic [IDX_W-1:0] wrapInc(input logic [IDX_W-1:0] p,
                                               input logic [DEPTH_W-1:0] d);
    return (int'(p) >= int'(d) - 1) ? '0 : p + IDX_W'(1);
  endfunction

  always_comb begin
    if (cnfg_depth == '0 || int'(cnfg_depth) > DEPTH) cntDepth = DEPTH_W'(DEPTH);
    else                                              cntDepth = cnfg_depth;
  end

  // Priority clr > rd > add; a pending clear blocks everything below it even if its channel is invalid.
  assign add_rdy = ~rd_req & ~clr_req;
  assign clrGo   = ~sw_rst & clr_req & (int'(clr_ch) < NUM_CH);
  assign rdGo    = ~sw_rst & ~clr_req & rd_req & (int'(rd_ch) < NUM_CH);
  assign addGo   = ~sw_rst & add_rdy & add_req & (int'(add_ch) < NUM_CH);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)       fsm_cs <= IDLE;
    else if (sw_rst) fsm_cs <= IDLE;
    else             fsm_cs <= fsm_ns;
  end

  always_comb begin
    fsm_ns = IDLE;
    if (clrGo)      fsm_ns = CLR;
    else if (rdGo)  fsm_ns = RD;
    else if (addGo) fsm_ns = ADD;
  end

  always_comb begin
    o_valid = (fsm_cs == RD);
  end

  always_comb begin
    for (int c = 0; c < NUM_CH; c++) begin
      head_d[c] = head_q[c];
      tail_d[c] = tail_q[c];
      cnt_d[c]  = cnt_q[c];
    end
    if (clrGo) begin
      head_d[clr_ch] = '0;
      tail_d[clr_ch] = '0;
      cnt_d[clr_ch]  = '0;
    end else if (addGo) begin
      tail_d[add_ch] = wrapInc(tail_q[add_ch], cntDepth);
      // A full channel overwrites its oldest element, so the window slides instead of growing.
      if (full[add_ch]) head_d[add_ch] = wrapInc(head_q[add_ch], cntDepth);
      else              cnt_d[add_ch]  = cnt_q[add_ch] + DEPTH_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn || sw_rst) begin
      for (int c = 0; c < NUM_CH; c++) begin
        head_q[c] <= '0;
        tail_q[c] <= '0;
        cnt_q[c]  <= '0;
      end
      oCh_q <= '0;
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        head_q[c] <= head_d[c];
        tail_q[c] <= tail_d[c];
        cnt_q[c]  <= cnt_d[c];
      end
      if (rdGo) oCh_q <= rd_ch;
    end
  end

  always_comb begin
    for (int c = 0; c < NUM_CH; c++) begin
      full[c]  = (cnt_q[c] == cntDepth);
      empty[c] = (cnt_q[c] == '0);
      fullness[c*DEPTH_W +: DEPTH_W] = cnt_q[c];
    end
  end

  always_comb begin
    rdSum = {1'b0, head_q[rd_ch]} + {1'b0, rd_idx};
    if (int'(rdSum) >= int'(cntDepth)) rdLocal = rdSum - (IDX_W+1)'(cntDepth);
    else                               rdLocal = rdSum;
    if (rdGo) memAddr = ADDR_W'(int'(rd_ch) * DEPTH + int'(rdLocal));
    else      memAddr = ADDR_W'(int'(add_ch) * DEPTH + int'(tail_q[add_ch]));
  end

  // Single port: at most one of write or read per cycle, selected by the accepted op.
  always_ff @(posedge clk) begin
    if (addGo)     mem[memAddr] <= i_data;
    else if (rdGo) rdData_q     <= mem[memAddr];
  end

  assign o_ch = oCh_q;

`ifdef GEN_BUF_IDX_CHECK_EN
  logic rdErr_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)       rdErr_q <= 1'b0;
    else if (sw_rst) rdErr_q <= 1'b0;
    else             rdErr_q <= rdGo & (int'(rd_idx) >= int'(cnt_q[rd_ch]));
  end

  assign rd_err = rdErr_q;
  assign o_data = rdErr_q ? '0 : rdData_q;
`else
  assign rd_err = 1'b0;
  assign o_data = rdData_q;
`endif

endmodule

// File: tb/tb_gen_multich_buffer_with_spmem.sv
// Directed bench for gen_multich_buffer_with_spmem; reads are checked by a scoreboard monitor.
module tb_gen_multich_buffer_with_spmem;

  localparam int DATA_W  = 8;
  localparam int DEPTH   = 100;
  localparam int NUM_CH  = 4;
  localparam int DEPTH_W = $clog2(DEPTH + 1);
  localparam int IDX_W   = $clog2(DEPTH);
  localparam int CH_W    = 2;

  logic                      clk = 1'b0;
  logic                      rstn;
  logic                      sw_rst;
  logic [DEPTH_W-1:0]        cnfg_depth;
  logic                      clr_req;
  logic [CH_W-1:0]           clr_ch;
  logic                      add_req;
  logic [CH_W-1:0]           add_ch;
  logic [DATA_W-1:0]         i_data;
  logic                      add_rdy;
  logic                      rd_req;
  logic [CH_W-1:0]           rd_ch;
  logic [IDX_W-1:0]          rd_idx;
  logic                      o_valid;
  logic [CH_W-1:0]           o_ch;
  logic [DATA_W-1:0]         o_data;
  logic [NUM_CH-1:0]         full;
  logic [NUM_CH-1:0]         empty;
  logic [NUM_CH*DEPTH_W-1:0] fullness;
  logic                      rd_err;

  int testsRun = 0;
  int testsFailed = 0;

  typedef struct {
    logic [CH_W-1:0]   ch;
    logic [DATA_W-1:0] data;
    logic              err;
  } expRsp_t;

  expRsp_t expQ [$];

  gen_multich_buffer_with_spmem #(
    .DATA_W(DATA_W), .DEPTH(DEPTH), .NUM_CH(NUM_CH), .SIM_DLY(1)
  ) dut (
    .clk(clk), .rstn(rstn), .sw_rst(sw_rst), .cnfg_depth(cnfg_depth),
    .clr_req(clr_req), .clr_ch(clr_ch),
    .add_req(add_req), .add_ch(add_ch), .i_data(i_data), .add_rdy(add_rdy),
    .rd_req(rd_req), .rd_ch(rd_ch), .rd_idx(rd_idx),
    .o_valid(o_valid), .o_ch(o_ch), .o_data(o_data),
    .full(full), .empty(empty), .fullness(fullness), .rd_err(rd_err)
  );

  always #5 clk = ~clk;

  // Compares one observed value against the bench's hand-computed expectation.
  task automatic checkOutput(input string name, input int actual, input int expected);
    testsRun++;
    if (actual != expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  function automatic int fillOf(input int c);
    return int'(fullness[c*DEPTH_W +: DEPTH_W]);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input int op, input int ch, input int val);
    case (op)
      0: begin add_req = 1'b1; add_ch = CH_W'(ch); i_data = DATA_W'(val); tick(); add_req = 1'b0; end
      1: begin clr_req = 1'b1; clr_ch = CH_W'(ch); tick(); clr_req = 1'b0; end
      default: begin rd_req = 1'b1; rd_ch = CH_W'(ch); rd_idx = IDX_W'(val); tick(); rd_req = 1'b0; end
    endcase
  endtask

  task automatic expectRead(input int ch, input int idx, input int data, input bit err);
    expRsp_t e;
    e.ch = CH_W'(ch); e.data = DATA_W'(data); e.err = err;
    expQ.push_back(e);
    applyStimulus(2, ch, idx);
  endtask

  // Monitor: every response pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (o_valid) begin
      if (expQ.size() == 0) begin
        checkOutput("unexpected o_valid", 1, 0);
      end else begin
        expRsp_t e;
        e = expQ.pop_front();
        checkOutput("rsp o_ch", int'(o_ch), int'(e.ch));
        checkOutput("rsp o_data", int'(o_data), int'(e.data));
        checkOutput("rsp rd_err", int'(rd_err), int'(e.err));
      end
    end
  end

  initial begin
    rstn = 1'b0; sw_rst = 1'b0; cnfg_depth = DEPTH_W'(4);
    clr_req = 1'b0; clr_ch = '0; add_req = 1'b0; add_ch = '0; i_data = '0;
    rd_req = 1'b0; rd_ch = '0; rd_idx = '0;
    repeat (3) tick();
    checkOutput("reset fullness", int'(fullness), 0);
    checkOutput("reset empty", int'(empty), 15);
    checkOutput("reset full", int'(full), 0);
    checkOutput("reset o_valid", int'(o_valid), 0);
    checkOutput("reset o_ch", int'(o_ch), 0);
    checkOutput("reset rd_err", int'(rd_err), 0);
    rstn = 1'b1;
    tick();

    for (int v = 1; v <= 3; v++) applyStimulus(0, 2, v);
    checkOutput("ch2 fullness", fillOf(2), 3);
    checkOutput("ch2 empty", int'(empty), 4'b1011);
    checkOutput("ch2 full", int'(full), 0);
    for (int i = 0; i < 3; i++) expectRead(2, i, i + 1, 1'b0);

    for (int v = 1; v <= 6; v++) applyStimulus(0, 0, v);
    checkOutput("ch0 full", int'(full[0]), 1);
    checkOutput("ch0 fullness", fillOf(0), 4);
    for (int i = 0; i < 4; i++) expectRead(0, i, i + 3, 1'b0);

    for (int v = 10; v <= 13; v++) applyStimulus(0, 1, v);
    applyStimulus(0, 3, 20);
    applyStimulus(0, 3, 21);
    checkOutput("ch1 full", int'(full[1]), 1);
    applyStimulus(1, 1, 0);
    checkOutput("clr ch1 empty", int'(empty[1]), 1);
    checkOutput("clr ch1 fullness", fillOf(1), 0);
    checkOutput("ch3 kept fullness", fillOf(3), 2);
    expectRead(3, 1, 21, 1'b0);

    begin
      expRsp_t e;
      e.ch = 2'd3; e.data = 8'd20; e.err = 1'b0;
      expQ.push_back(e);
      rd_req = 1'b1; rd_ch = 2'd3; rd_idx = '0;
      add_req = 1'b1; add_ch = 2'd3; i_data = 8'd22;
      #1;
      checkOutput("collision add_rdy", int'(add_rdy), 0);
      tick();
      rd_req = 1'b0;
      checkOutput("collision fullness", fillOf(3), 2);
      #1;
      checkOutput("held add_rdy", int'(add_rdy), 1);
      tick();
      add_req = 1'b0;
      checkOutput("held add fullness", fillOf(3), 3);
      expectRead(3, 2, 22, 1'b0);
    end

    applyStimulus(1, 0, 0);
    applyStimulus(0, 0, 7);
    applyStimulus(0, 0, 8);
    checkOutput("ch0 refill", fillOf(0), 2);
    expectRead(0, 0, 7, 1'b0);
`ifdef GEN_BUF_IDX_CHECK_EN
    expectRead(0, 3, 0, 1'b1);
`else
    expectRead(0, 3, 4, 1'b0);
`endif
    tick();

    sw_rst = 1'b1;
    add_req = 1'b1; add_ch = 2'd1; i_data = 8'd9;
    tick();
    sw_rst = 1'b0; add_req = 1'b0;
    checkOutput("sw_rst fullness", int'(fullness), 0);
    checkOutput("sw_rst empty", int'(empty), 15);

    applyStimulus(0, 0, 5);
    checkOutput("post sw_rst add", fillOf(0), 1);
    rd_req = 1'b1; rd_ch = 2'd0; rd_idx = '0;
    tick();
    rd_req = 1'b0;
    rstn = 1'b0;
    #1;
    checkOutput("rstn drops o_valid", int'(o_valid), 0);
    tick();
    rstn = 1'b1;
    tick();
    checkOutput("rstn fullness", int'(fullness), 0);

    repeat (3) tick();
    checkOutput("responses outstanding", expQ.size(), 0);
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/gen_multich_buffer_with_spmem.md
# gen_multich_buffer_with_spmem

Multi-channel sliding-window history buffer built on a single-port memory. Holds `NUM_CH` independent circular queues, each with a runtime-configurable depth. Adds overwrite the oldest element once a channel is full. Any stored element is randomly readable by age index. It sits beside the single-channel history buffer in `gen_componentes` and serves datapaths that keep per-lane sample histories without one memory per lane.

## Interface
- `DATA_W`, 8: element width.
- `DEPTH`, 100: maximum elements per channel.
- `NUM_CH`, 4: channel count (≥1).
- `SIM_DLY`, 1: simulation delay passed to memory model.
- `DEPTH_W`, `$clog2(DEPTH+1)`: local; do not override.
- `IDX_W`, `$clog2(DEPTH)`: local; do not override.
- `CH_W`, `max(1,$clog2(NUM_CH))`: local; do not override.
- `clk` in 1: clock.
- `rstn` in 1: reset, asynchronous, active-low.
- `sw_rst` in 1: synchronous clear of all state except memory contents.
- `cnfg_depth` in `DEPTH_W`: active depth, shared by all channels. Legal range 1..DEPTH; 0 or >DEPTH is treated as DEPTH. Change only in the cycle of or after `sw_rst`.
- `clr_req` in 1, `clr_ch` in `CH_W`: empty one channel.
- `add_req` in 1, `add_ch` in `CH_W`, `i_data` in `DATA_W`: append an element.
- `add_rdy` out 1: add accepted this cycle. Combinational: `~rd_req & ~clr_req`.
- `rd_req` in 1, `rd_ch` in `CH_W`, `rd_idx` in `IDX_W`: read element; idx 0 is the oldest.
- `o_valid` out 1, `o_ch` out `CH_W`, `o_data` out `DATA_W`: read response.
- `full` out `NUM_CH`, `empty` out `NUM_CH`: per-channel flags.
- `fullness` out `NUM_CH*DEPTH_W`: per-channel count; channel c occupies bits `[c*DEPTH_W +: DEPTH_W]`.
- `rd_err` out 1: see Configuration.

## Operation
- Memory is `NUM_CH*DEPTH` words. Physical address = `ch*DEPTH + local`. Exactly one access per cycle.
- Per channel: `head`, `tail` (IDX_W), `cnt` (DEPTH_W).
- Priority: clr > rd > add. One operation is accepted per cycle.
- FSM `fsm_cs` records the last accepted op: IDLE=0, RD=1, ADD=2, CLR=3. The next state is the accepted op, or IDLE if there is none. It is used for `o_valid` generation and debug.
- ADD on channel c:
  - Write `i_data` at `tail`.
  - `tail` wraps at `cnt_depth-1` to 0.
  - If `full[c]`, `head` advances with the same wrap and `cnt` is unchanged (overwrite oldest). Otherwise `cnt+1`.
  - `empty[c]` is cleared.
  - `full[c]` is set when `cnt_nx == cnt_depth`.
- RD on channel c:
  - Local address = `head+rd_idx`. If the sum is ≥ `cnt_depth`, subtract `cnt_depth`. Compute with `IDX_W+1` bits.
  - No pointer change.
- CLR on channel c: `head`, `tail`, `cnt` ← 0; `empty[c]`←1; `full[c]`←0. Memory is untouched.
- `rd_ch`/`add_ch`/`clr_ch` ≥ NUM_CH: the request is ignored. `add_rdy` still follows its formula, and no state changes.
- `rd_idx ≥ cnt` without the macro: the memory word is returned as-is (stale or undefined data), and `o_valid` still asserts.

## Timing
- Reset (rstn low or sw_rst): all `head`/`tail`/`cnt` = 0, `full`=0, `empty`=all-ones, `fullness`=0, `o_valid`=0, `o_ch`=0, `rd_err`=0, `fsm_cs`=IDLE. `o_data` is undefined until the first read.
- Read latency is 1 cycle: `o_valid`, `o_ch` and `o_data` are valid in the cycle after an accepted `rd_req`. `o_valid` is a single-cycle pulse per read.
- Back-to-back reads: one response per cycle.
- Flags/fullness update at the clock edge that accepts the op. A read in the next cycle sees the new pointers.
- Simultaneous `rd_req` and `add_req`: the read executes, `add_rdy`=0, and the add must be held by the requester.
- `rstn` asserted mid-read: `o_valid` is forced 0 immediately (async). The pending response is dropped.
- `sw_rst` in the same cycle as any request: `sw_rst` wins, and no op is accepted.

## Configuration
- `GEN_BUF_IDX_CHECK_EN` defined:
  - A read with `rd_idx ≥ cnt[rd_ch]` (including an empty channel) still returns a response.
  - `o_data`=0 and `rd_err`=1, aligned with `o_valid`.
- Undefined: `rd_err` is tied 0, and out-of-range reads return raw memory.

## Test plan
- Reset then depth 4, NUM_CH 4:
  - Add 1,2,3 to ch2 → `fullness[ch2]`=3, `empty`=4'b1011, `full`=0.
  - Read idx0..2 → `o_data` 1,2,3 each 1 cycle later with `o_ch`=2.
- Overwrite at depth 4: add 1..6 to ch0 → `full[0]`=1, `fullness`=4. Read idx0..3 → 3,4,5,6.
- Channel isolation:
  - Add 10..13 to ch1 and 20..21 to ch3.
  - Clear ch1 → `empty[1]`=1, `fullness` of ch3 still 2.
  - Read ch3 idx1 → 21.
- Collision: `rd_req` and `add_req` together → `add_rdy`=0, `fullness` unchanged. Add held one more cycle → accepted.
- Macro on, ch0 holds 2 elements: read idx3 → `o_valid`=1, `o_data`=0, `rd_err`=1. Macro off: `rd_err`=0.
- Reset corners:
  - `sw_rst` with `add_req` → `fullness` stays 0.
  - `rstn` low the cycle after a `rd_req` → no `o_valid` pulse.
